spi_rom_read_seq: RTL

Sequencer for the external SPI flash ROM on the VGA design's `uio` pins. It accepts a read request (start address and byte count) from the display logic. It then runs the whole transaction: drives `/CS`, `SCLK` and `io0`, serialises the read command and 24-bit address, turns `io0` around in quad mode, and returns the received bytes one strobe at a time. It sits between the pixel/line-fetch logic and the `uio_out`/`uio_oe`/`uio_in` pin mapping.

---
 rtl/spi_rom_read_seq.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/spi_rom_read_seq.sv
// spi_rom_read_seq
// Runs a complete read transaction on the external SPI flash ROM. A request
// carries a start address and a byte count. The sequencer sends the read
// command (0x03 single, 0x6B quad-output) and the 24-bit address MSB-first on
// io0. In quad mode it releases io0 for the dummy byte and the data. Each
// received byte is returned with a one-cycle strobe.
//
// Ports:
//   clk, reset            pixel clock, synchronous active-high reset
//   start, quad, addr,    request strobe and its parameters, latched when the
//   len                   request is accepted (len = 0 means 2^LEN_W bytes)
//   abort                 cuts the running transaction short
//   busy                  transaction in progress
//   data, data_valid      received byte and its one-cycle strobe
//   done                  one-cycle pulse on return to idle
//   spi_cs_n, spi_sclk    flash chip select (active low), SPI clock (clk/2, mode 0)
//   spi_out0, spi_oe0     io0 output value and output enable (1 = drive)
//   spi_in                {io3, io2, io1, io0} from the pads
module spi_rom_read_seq #(
    parameter int LEN_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             quad,
    input  logic [23:0]      addr,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic             busy,
    output logic [7:0]       data,
    output logic             data_valid,
    output logic             done,
    output logic             spi_cs_n,
    output logic             spi_sclk,
    output logic             spi_out0,
    output logic             spi_oe0,
    input  logic [3:0]       spi_in
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_END
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             phase;
    logic [4:0]       bit_cnt;
    logic [31:0]      shift_out;
    logic [7:0]       shift_in;
    logic [LEN_W-1:0] byte_cnt;
    logic             quad_r;
    logic             active;
    logic             active_next;
    logic             pulse_end;
    logic             byte_last;
    logic [7:0]       next_byte;

    // The flash sees a clock only while one of the four bus states is active.
    // pulse_end marks the clk edge that ends a high phase: the edge where
    // SCLK falls, io0 advances and the pads are sampled.
    assign active      = (state == ST_CMD) || (state == ST_ADDR) ||
                         (state == ST_DUMMY) || (state == ST_DATA);
    assign active_next = (state_next == ST_CMD) || (state_next == ST_ADDR) ||
                         (state_next == ST_DUMMY) || (state_next == ST_DATA);
    assign pulse_end   = active && phase;

    // In DATA, bit_cnt counts SCLK pulses within the current byte.
    // A single-mode byte takes 8 pulses. A quad-mode byte takes 2 nibbles.
    assign byte_last = quad_r ? (bit_cnt == 5'd1) : (bit_cnt == 5'd7);
    assign next_byte = quad_r ? {shift_in[3:0], spi_in} : {shift_in[6:0], spi_in[1]};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Abort wins over every bus-state transition. END always
    // runs its two cycles so /CS stays high long enough before the next request.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_CMD;
            ST_CMD: begin
                if (abort)                           state_next = ST_END;
                else if (pulse_end && bit_cnt == 5'd7) state_next = ST_ADDR;
            end
            ST_ADDR: begin
                if (abort)                            state_next = ST_END;
                else if (pulse_end && bit_cnt == 5'd23) state_next = quad_r ? ST_DUMMY : ST_DATA;
            end
            ST_DUMMY: begin
                if (abort)                           state_next = ST_END;
                else if (pulse_end && bit_cnt == 5'd7) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (abort)                                                  state_next = ST_END;
                else if (pulse_end && byte_last && byte_cnt == LEN_W'(1)) state_next = ST_END;
            end
            ST_END:   if (bit_cnt == 5'd1) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Output decode. io0 carries the command/address shifter only in CMD and
    // ADDR. A quad read releases the pin from the dummy byte onward. END and
    // IDLE drive it again.
    always_comb begin
        busy     = (state != ST_IDLE);
        spi_cs_n = !active;
        spi_sclk = active && phase;
        spi_out0 = 1'b0;
        spi_oe0  = 1'b1;
        if (state == ST_CMD || state == ST_ADDR) begin
            spi_out0 = shift_out[31];
        end
        if (quad_r && (state == ST_DUMMY || state == ST_DATA)) begin
            spi_oe0 = 1'b0;
        end
    end

    // Datapath: SCLK phase, pulse counter, the outgoing command/address
    // shifter, the incoming byte assembler and the byte down-counter.
    // An abort on a sampling edge discards the partial byte, so no strobe
    // escapes after the abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase      <= 1'b0;
            bit_cnt    <= 5'd0;
            shift_out  <= 32'd0;
            shift_in   <= 8'd0;
            byte_cnt   <= '0;
            quad_r     <= 1'b0;
            data       <= 8'd0;
            data_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            done       <= (state == ST_END) && (state_next == ST_IDLE);
            phase      <= (active && active_next) ? ~phase : 1'b0;

            if (state_next != state) begin
                bit_cnt <= 5'd0;
            end else if (state == ST_END) begin
                bit_cnt <= bit_cnt + 5'd1;
            end else if (pulse_end) begin
                bit_cnt <= (state == ST_DATA && byte_last) ? 5'd0 : bit_cnt + 5'd1;
            end

            if (state == ST_IDLE && start) begin
                quad_r    <= quad;
                byte_cnt  <= len;
                shift_out <= {(quad ? 8'h6B : 8'h03), addr};
            end else if (pulse_end && (state == ST_CMD || state == ST_ADDR)) begin
                shift_out <= {shift_out[30:0], 1'b0};
            end

            if (pulse_end && state == ST_DATA && !abort) begin
                shift_in <= next_byte;
                if (byte_last) begin
                    data       <= next_byte;
                    data_valid <= 1'b1;
                    byte_cnt   <= byte_cnt - LEN_W'(1);
                end
            end
        end
    end

endmodule
